// File: rtl/eth_e2h_pkt_gate_pkg.sv
// Shared types and widths for the e2h store-and-forward packet gate.
// Optional feature macro: ETH_E2H_PKT_GATE_TUSER_ERR_EN.
package eth_e2h_pkt_gate_pkg;

  localparam int DATA_W  = 64;
  localparam int KEEP_W  = 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DROP  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] v,
    input logic             inc,
    input logic             clr
  );
    if (clr)
      return '0;
    if (inc && (v != '1))
      return v + CNT_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/eth_e2h_pkt_gate_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// Part of eth_e2h_pkt_gate (macro ETH_E2H_PKT_GATE_TUSER_ERR_EN unused here).
module eth_e2h_pkt_gate_ram
  import eth_e2h_pkt_gate_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = ENTRY_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re)
      rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eth_e2h_pkt_gate.sv
// Store-and-forward gate: buffers whole frames, drops ones that do not fit.
// Define ETH_E2H_PKT_GATE_TUSER_ERR_EN to drop tuser-flagged frames.
module eth_e2h_pkt_gate
  import eth_e2h_pkt_gate_pkg::*;
#(
  parameter int SIZE          = 10,
  parameter int MAX_PKT_WORDS = 1200
) (
  input  logic              bus_clk,
  input  logic              bus_aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
  input  logic              s_tuser,
  output logic [CNT_W-1:0]  err_count,
`endif
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [SIZE:0]     occupancy
);

  localparam int PW = SIZE + 1;
  localparam logic [SIZE:0] CAP  = PW'((1 << SIZE) - 1);
  localparam logic [SIZE:0] MAXW = PW'(MAX_PKT_WORDS);

  wr_state_e state_q, state_d;
  logic s_tready_q, s_tready_d;
  logic [SIZE:0] wr_ptr_q, wr_ptr_d;
  logic [SIZE:0] commit_q, commit_d;
  logic [SIZE:0] commit_vis_q, commit_vis_d;
  logic [SIZE:0] rd_ptr_q, rd_ptr_d;
  logic [SIZE:0] wcnt_q, wcnt_d;
  logic [SIZE:0] occ_q, occ_d;
  logic rd_vld_q, rd_vld_d;
  logic [1:0] skid_cnt_q, skid_cnt_d;
  entry_t head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] pkt_q, pkt_d, drop_q, drop_d;

  logic beat, bad, we, re, pop;
  logic pkt_inc, drop_inc;
  logic [SIZE:0] free, n_words;
  entry_t wentry, rentry;
  logic [ENTRY_W-1:0] rdata;

`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
  logic err_inc;
  logic [CNT_W-1:0] err_q, err_d;
  assign bad = s_tuser;
`else
  assign bad = 1'b0;
`endif

  assign beat   = s_tvalid && s_tready_q;
  assign free   = CAP - (wr_ptr_q - rd_ptr_q);
  assign wentry = '{last: s_tlast, keep: s_tkeep, data: s_tdata};

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    wcnt_d   = wcnt_q;
    we       = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
    err_inc  = 1'b0;
`endif
    n_words  = (state_q == S_IDLE) ? PW'(1) : wcnt_q + PW'(1);
    if (beat) begin
      case (state_q)
        S_IDLE, S_WRITE: begin
          if ((free != '0) && (n_words <= MAXW)) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            wcnt_d   = n_words;
            state_d  = s_tlast ? S_IDLE : S_WRITE;
            if (s_tlast && bad) begin
              wr_ptr_d = commit_q;
              drop_inc = 1'b1;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
              err_inc  = 1'b1;
`endif
            end else if (s_tlast) begin
              commit_d = wr_ptr_q + PW'(1);
              pkt_inc  = 1'b1;
            end
          end else begin
            // rewind the partial frame; tlast here ends the drop at once
            wr_ptr_d = commit_q;
            drop_inc = s_tlast;
            state_d  = s_tlast ? S_IDLE : S_DROP;
          end
        end
        S_DROP: begin
          if (s_tlast) begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // reads trail commit by one cycle; skid credit keeps 1 word/cycle
  assign pop = (skid_cnt_q != 2'd0) && m_tready;
  assign re  = (rd_ptr_q != commit_vis_q) &&
               ((3'(skid_cnt_q) + 3'(rd_vld_q)) < (3'd2 + 3'(pop)));
  assign rentry = entry_t'(rdata);

  always_comb begin
    commit_vis_d = commit_q;
    s_tready_d   = 1'b1;
    rd_ptr_d     = rd_ptr_q + PW'(re);
    rd_vld_d     = re;
    head_d       = head_q;
    tail_d       = tail_q;
    skid_cnt_d   = skid_cnt_q;
    case ({rd_vld_q, pop})
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          head_d = rentry;
        end else begin
          head_d = tail_q;
          tail_d = rentry;
        end
      end
      2'b01: begin
        head_d     = tail_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b10: begin
        if (skid_cnt_q == 2'd0)
          head_d = rentry;
        else
          tail_d = rentry;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      default: ;
    endcase
    occ_d = wr_ptr_d - rd_ptr_d + PW'(skid_cnt_d) + PW'(rd_vld_d);
    pkt_d  = cnt_next(pkt_q, pkt_inc, clear_stats);
    drop_d = cnt_next(drop_q, drop_inc, clear_stats);
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
    err_d  = cnt_next(err_q, err_inc, clear_stats);
`endif
  end

  always_ff @(posedge bus_clk or negedge bus_aresetn) begin
    if (!bus_aresetn) begin
      state_q      <= S_IDLE;
      s_tready_q   <= 1'b0;
      wr_ptr_q     <= '0;
      commit_q     <= '0;
      commit_vis_q <= '0;
      rd_ptr_q     <= '0;
      wcnt_q       <= '0;
      occ_q        <= '0;
      rd_vld_q     <= 1'b0;
      skid_cnt_q   <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      pkt_q        <= '0;
      drop_q       <= '0;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      s_tready_q   <= s_tready_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_q     <= commit_d;
      commit_vis_q <= commit_vis_d;
      rd_ptr_q     <= rd_ptr_d;
      wcnt_q       <= wcnt_d;
      occ_q        <= occ_d;
      rd_vld_q     <= rd_vld_d;
      skid_cnt_q   <= skid_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      pkt_q        <= pkt_d;
      drop_q       <= drop_d;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  eth_e2h_pkt_gate_ram #(
    .AW(SIZE),
    .DW(ENTRY_W)
  ) u_ram (
    .clk  (bus_clk),
    .we   (we),
    .waddr(wr_ptr_q[SIZE-1:0]),
    .wdata(wentry),
    .re   (re),
    .raddr(rd_ptr_q[SIZE-1:0]),
    .rdata(rdata)
  );

  assign s_tready   = s_tready_q;
  assign m_tvalid   = (skid_cnt_q != 2'd0);
  assign m_tdata    = head_q.data;
  assign m_tkeep    = head_q.keep;
  assign m_tlast    = head_q.last;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
  assign occupancy  = occ_q;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
  assign err_count  = err_q;
`endif

endmodule

// File: tb/tb_eth_e2h_pkt_gate.sv
// Bench for eth_e2h_pkt_gate: two instances (SIZE=4/MAX=15, SIZE=6/MAX=6).
// Covers ETH_E2H_PKT_GATE_TUSER_ERR_EN scenarios when that macro is defined.
module tb_eth_e2h_pkt_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tvalid, clear_stats;
  logic [1:0]  rdy_mode;
  logic        rnd_bit;
  logic        m_tready;
  logic        sel;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
  logic        s_tuser;
  logic        tuser_bad;
  logic [31:0] a_err, b_err;
`endif

  logic        a_srdy, a_mv, a_ml, b_srdy, b_mv, b_ml;
  logic [63:0] a_md, b_md;
  logic [7:0]  a_mk, b_mk;
  logic [31:0] a_drop, a_pkt, b_drop, b_pkt;
  logic [4:0]  a_occ;
  logic [6:0]  b_occ;

  eth_e2h_pkt_gate #(.SIZE(4), .MAX_PKT_WORDS(15)) u_a (
    .bus_clk(clk), .bus_aresetn(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(a_srdy),
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
    .s_tuser(s_tuser), .err_count(a_err),
`endif
    .m_tdata(a_md), .m_tkeep(a_mk), .m_tlast(a_ml),
    .m_tvalid(a_mv), .m_tready(m_tready),
    .clear_stats(clear_stats), .drop_count(a_drop),
    .pkt_count(a_pkt), .occupancy(a_occ)
  );

  eth_e2h_pkt_gate #(.SIZE(6), .MAX_PKT_WORDS(6)) u_b (
    .bus_clk(clk), .bus_aresetn(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(b_srdy),
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
    .s_tuser(s_tuser), .err_count(b_err),
`endif
    .m_tdata(b_md), .m_tkeep(b_mk), .m_tlast(b_ml),
    .m_tvalid(b_mv), .m_tready(m_tready),
    .clear_stats(clear_stats), .drop_count(b_drop),
    .pkt_count(b_pkt), .occupancy(b_occ)
  );

  logic        mv, ml, srdy;
  logic [63:0] md;
  logic [7:0]  mk;
  logic [31:0] drop, pkt;
  logic [7:0]  occ;
  assign mv   = sel ? b_mv : a_mv;
  assign ml   = sel ? b_ml : a_ml;
  assign md   = sel ? b_md : a_md;
  assign mk   = sel ? b_mk : a_mk;
  assign srdy = sel ? b_srdy : a_srdy;
  assign drop = sel ? b_drop : a_drop;
  assign pkt  = sel ? b_pkt : a_pkt;
  assign occ  = sel ? 8'(b_occ) : 8'(a_occ);

  always @(posedge clk) rnd_bit <= 1'($urandom);
  assign m_tready = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];

  int checks = 0;
  int failures = 0;
  int nrdy;
  logic [72:0] out_q[$];
  logic [72:0] frm_q[$];
  logic [72:0] exp_q[$];

  logic        mon_en;
  logic        stall_prev;
  logic [72:0] prev_w;
  int          stall_viol;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev && (!mv || {ml, mk, md} !== prev_w))
        stall_viol <= stall_viol + 1;
      if (mv && m_tready)
        out_q.push_back({ml, mk, md});
      stall_prev <= mv && !m_tready;
      prev_w <= {ml, mk, md};
    end else begin
      stall_prev <= 1'b0;
      stall_viol <= 0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    mon_en = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic send_frame(input int len);
    frm_q.delete();
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata = {$urandom, $urandom};
      s_tkeep = (i % 4 == 1) ? 8'h00 : 8'($urandom);
      s_tlast = (i == len - 1);
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
      s_tuser = s_tlast && tuser_bad;
`endif
      if (!srdy) nrdy++;
      frm_q.push_back({s_tlast, s_tkeep, s_tdata});
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
    s_tuser = 1'b0;
`endif
  endtask

  task automatic wait_out(input int n, input int budget);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_srdy !== 1'b0) begin
      failures++; $display("FAIL rst_s_tready got=%b exp=0", a_srdy);
    end
    checks++;
    if ({a_mv, a_ml, a_mk, a_md} !== 74'd0) begin
      failures++; $display("FAIL rst_m_out got=%h exp=0", {a_mv, a_ml, a_mk, a_md});
    end
    checks++;
    if ({a_pkt, a_drop, a_occ} !== 69'd0) begin
      failures++; $display("FAIL rst_counters got=%h exp=0", {a_pkt, a_drop, a_occ});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_srdy !== 1'b0) begin
      failures++; $display("FAIL rdy_before_edge got=%b exp=0", a_srdy);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({a_srdy, b_srdy} !== 2'b11) begin
      failures++; $display("FAIL rdy_after_edge got=%b exp=11", {a_srdy, b_srdy});
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (a_srdy !== 1'b1) begin
      failures++; $display("FAIL rdy_stays got=%b exp=1", a_srdy);
    end
  endtask

  task automatic test_single_frame();
    int lat = 0;
    do_reset();
    sel = 1'b0;
    rdy_mode = 2'd1;
    send_frame(5);
    exp_q = frm_q;
    while (lat < 20) begin
      @(negedge clk);
      if (mv) break;
      lat++;
    end
    checks++;
    if (lat != 3) begin
      failures++; $display("FAIL latency got=%0d exp=3", lat);
    end
    wait_out(5, 50);
    checks++;
    if (out_q.size() != 5) begin
      failures++; $display("FAIL single_count got=%0d exp=5", out_q.size());
    end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL single_word%0d got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt !== 32'd1 || drop !== 32'd0) begin
      failures++; $display("FAIL single_stats got=%0d/%0d exp=1/0", pkt, drop);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    sel = 1'b0;
    rdy_mode = 2'd0;
    send_frame(10);
    exp_q = frm_q;
    send_frame(8);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (pkt !== 32'd1 || drop !== 32'd1) begin
      failures++; $display("FAIL ovf_stats got=%0d/%0d exp=1/1", pkt, drop);
    end
    checks++;
    if (occ !== 8'd10) begin
      failures++; $display("FAIL ovf_occupancy got=%0d exp=10", occ);
    end
    checks++;
    if (!mv || {ml, mk, md} !== exp_q[0]) begin
      failures++; $display("FAIL ovf_head got=%b/%h exp=1/%h", mv, {ml, mk, md}, exp_q[0]);
    end
    rdy_mode = 2'd1;
    wait_out(10, 100);
    checks++;
    if (out_q.size() != 10) begin
      failures++; $display("FAIL ovf_count got=%0d exp=10", out_q.size());
    end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (occ !== 8'd0) begin
      failures++; $display("FAIL ovf_drained got=%0d exp=0", occ);
    end
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    checks++;
    if (pkt !== 32'd0 || drop !== 32'd0) begin
      failures++; $display("FAIL clear_stats got=%0d/%0d exp=0/0", pkt, drop);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    sel = 1'b1;
    rdy_mode = 2'd1;
    nrdy = 0;
    send_frame(7);
    send_frame(3);
    exp_q = frm_q;
    wait_out(3, 50);
    checks++;
    if (out_q.size() != 3) begin
      failures++; $display("FAIL max_count got=%0d exp=3", out_q.size());
    end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL max_word%0d got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt !== 32'd1 || drop !== 32'd1) begin
      failures++; $display("FAIL max_stats got=%0d/%0d exp=1/1", pkt, drop);
    end
    checks++;
    if (nrdy != 0) begin
      failures++; $display("FAIL max_s_tready got=%0d low beats exp=0", nrdy);
    end
  endtask

  task automatic test_random();
    int kept = 0;
    int dropped = 0;
    int committed = 0;
    int timeouts = 0;
    int len, c;
    do_reset();
    sel = 1'b1;
    rdy_mode = 2'd2;
    exp_q.delete();
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 12);
      c = 0;
      // wait until the frame fits even if no prefetched word counts as freed
      while (len <= 6 && (63 - (committed - out_q.size())) < len && c < 500) begin
        @(posedge clk);
        #1;
        c++;
      end
      if (c >= 500) timeouts++;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_frame(len);
      if (len <= 6) begin
        foreach (frm_q[i]) exp_q.push_back(frm_q[i]);
        committed += len;
        kept++;
      end else begin
        dropped++;
      end
    end
    wait_out(exp_q.size(), 3000);
    checks++;
    if (timeouts != 0) begin
      failures++; $display("FAIL rnd_room_wait got=%0d timeouts exp=0", timeouts);
    end
    checks++;
    if (out_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rnd_count got=%0d exp=%0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rnd_word%0d got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt !== 32'(kept) || drop !== 32'(dropped)) begin
      failures++; $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d", pkt, drop, kept, dropped);
    end
    checks++;
    if (pkt + drop !== 32'd200) begin
      failures++; $display("FAIL rnd_total got=%0d exp=200", pkt + drop);
    end
    checks++;
    if (stall_viol != 0) begin
      failures++; $display("FAIL rnd_stall_stable got=%0d changes exp=0", stall_viol);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    sel = 1'b0;
    rdy_mode = 2'd0;
    send_frame(4);
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata = {$urandom, $urandom};
      s_tkeep = 8'hff;
      s_tlast = 1'b0;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (mv !== 1'b0 || occ !== 8'd0 || pkt !== 32'd0) begin
      failures++; $display("FAIL midrst_async got=%b/%0d/%0d exp=0/0/0", mv, occ, pkt);
    end
    do_reset();
    rdy_mode = 2'd1;
    send_frame(2);
    exp_q = frm_q;
    wait_out(2, 50);
    checks++;
    if (out_q.size() != 2) begin
      failures++; $display("FAIL midrst_count got=%0d exp=2", out_q.size());
    end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL midrst_word%0d got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt !== 32'd1 || drop !== 32'd0 || occ !== 8'd0) begin
      failures++; $display("FAIL midrst_stats got=%0d/%0d/%0d exp=1/0/0", pkt, drop, occ);
    end
  endtask

`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
  task automatic test_tuser();
    do_reset();
    sel = 1'b0;
    rdy_mode = 2'd1;
    tuser_bad = 1'b1;
    send_frame(4);
    tuser_bad = 1'b0;
    send_frame(3);
    exp_q = frm_q;
    wait_out(3, 50);
    checks++;
    if (out_q.size() != 3) begin
      failures++; $display("FAIL tuser_count got=%0d exp=3", out_q.size());
    end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL tuser_word%0d got=%h exp=%h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (a_err !== 32'd1 || drop !== 32'd1 || pkt !== 32'd1) begin
      failures++; $display("FAIL tuser_stats got=%0d/%0d/%0d exp=1/1/1", a_err, drop, pkt);
    end
  endtask
`endif

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    clear_stats = 1'b0;
    rdy_mode = 2'd0;
    sel = 1'b0;
    mon_en = 1'b0;
    nrdy = 0;
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
    s_tuser = 1'b0;
    tuser_bad = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_overflow();
    test_max_len();
    test_random();
    test_reset_mid_frame();
`ifdef ETH_E2H_PKT_GATE_TUSER_ERR_EN
    test_tuser();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
